// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, status codes, ALU functions
// and branch/cmov condition codes.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_HLT = 4'h2;
  localparam logic [3:0] STAT_ADR = 4'h3;
  localparam logic [3:0] STAT_INS = 4'h4;

  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  // ALU_ZERO covers OPQ with an undefined function code.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_XOR  = 3'd3,
    ALU_ZERO = 3'd4
  } alu_fun_t;

  function automatic logic is_exc(input logic [3:0] stat);
    return (stat == STAT_HLT) || (stat == STAT_ADR) || (stat == STAT_INS);
  endfunction

endpackage

// File: rtl/e_stage_if.sv
// Execute-stage bus: E_* pipeline-register fields in, e_* results and CC out.
interface e_stage_if #(parameter int XLEN = 64);
  logic [3:0]      E_icode, E_ifun, E_stat, E_dstE, E_dstM;
  logic [XLEN-1:0] E_valA, E_valB, E_valC;
  logic [3:0]      m_stat, W_stat;
  logic [XLEN-1:0] e_valE, e_valA;
  logic [3:0]      e_dstE, e_dstM, e_icode, e_ifun, e_stat;
  logic            e_Cnd;
  logic [2:0]      cc;

  modport master (
    output E_icode, E_ifun, E_stat, E_valA, E_valB, E_valC, E_dstE, E_dstM,
           m_stat, W_stat,
    input  e_valE, e_valA, e_dstE, e_dstM, e_Cnd, e_icode, e_ifun, e_stat, cc
  );

  modport slave (
    input  E_icode, E_ifun, E_stat, E_valA, E_valB, E_valC, E_dstE, E_dstM,
           m_stat, W_stat,
    output e_valE, e_valA, e_dstE, e_dstM, e_Cnd, e_icode, e_ifun, e_stat, cc
  );
endinterface

// File: rtl/alu64.sv
// Combinational ALU: result = alu_b op alu_a, flags = {ZF, SF, OF}.
module alu64
  import y86_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  alu_fun_t        alufun,
  output logic [XLEN-1:0] result,
  output logic [2:0]      flags
);
  logic ovf;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alufun)
      ALU_ADD: begin
        result = alu_b + alu_a;
        ovf    = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (result[XLEN-1] != alu_a[XLEN-1]);
      end
      ALU_SUB: begin
        result = alu_b - alu_a;
        ovf    = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (result[XLEN-1] != alu_b[XLEN-1]);
      end
      ALU_AND: result = alu_b & alu_a;
      ALU_XOR: result = alu_b ^ alu_a;
      default: result = '0;
    endcase
  end

  assign flags = {(result == '0), result[XLEN-1], ovf};
endmodule

// File: rtl/e_stage.sv
// Y86-64 execute stage: operand muxing, ALU, CC register, branch/cmov
// condition and cmov destination squash.
module e_stage
  import y86_pkg::*;
#(
  parameter int         XLEN  = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input logic         clk,
  input logic         rst,
  e_stage_if.slave    bus
);
  localparam logic [XLEN-1:0] PLUS8  = XLEN'(8);
  localparam logic [XLEN-1:0] MINUS8 = -PLUS8;

  logic [XLEN-1:0] alu_a, alu_b, alu_res;
  alu_fun_t        alufun;
  logic [2:0]      alu_flags;
  logic [2:0]      cc_q;
  logic            set_cc, cnd;
  logic            zf, sf, of;

  always_comb begin
    case (bus.E_icode)
      I_RRMOVQ, I_OPQ:                alu_a = bus.E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:   alu_a = bus.E_valC;
      I_CALL, I_PUSHQ:                alu_a = MINUS8;
      I_RET, I_POPQ:                  alu_a = PLUS8;
      default:                        alu_a = '0;
    endcase
  end

  always_comb begin
    case (bus.E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = bus.E_valB;
      default:                                                    alu_b = '0;
    endcase
  end

  always_comb begin
    alufun = ALU_ADD;
    if (bus.E_icode == I_OPQ)
      alufun = (bus.E_ifun[3:2] == 2'b00) ? alu_fun_t'({1'b0, bus.E_ifun[1:0]}) : ALU_ZERO;
  end

  alu64 #(.XLEN(XLEN)) u_alu (
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alufun (alufun),
    .result (alu_res),
    .flags  (alu_flags)
  );

  // An exception further down the pipe must not let a younger OPQ change CC.
  assign set_cc = (bus.E_icode == I_OPQ) && (bus.E_stat == STAT_AOK) &&
                  !is_exc(bus.m_stat) && !is_exc(bus.W_stat);

  always_ff @(posedge clk) begin
    if (rst)         cc_q <= 3'b100;
    else if (set_cc) cc_q <= alu_flags;
  end

  assign {zf, sf, of} = cc_q;

  always_comb begin
    cnd = 1'b0;
    case (bus.E_ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = (sf ^ of) | zf;
      C_L:      cnd = sf ^ of;
      C_E:      cnd = zf;
      C_NE:     cnd = !zf;
      C_GE:     cnd = !(sf ^ of);
      C_G:      cnd = !(sf ^ of) & !zf;
      default:  cnd = 1'b0;
    endcase
  end

  assign bus.e_valE  = alu_res;
  assign bus.e_valA  = bus.E_valA;
  assign bus.e_dstE  = ((bus.E_icode == I_RRMOVQ) && !cnd) ? RNONE : bus.E_dstE;
  assign bus.e_dstM  = bus.E_dstM;
  assign bus.e_Cnd   = cnd;
  assign bus.e_icode = bus.E_icode;
  assign bus.e_ifun  = bus.E_ifun;
  assign bus.e_stat  = bus.E_stat;
  assign bus.cc      = cc_q;
endmodule

// File: tb/tb_e_stage.sv
// Directed self-checking bench for the Y86-64 execute stage.
module tb_e_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

  e_stage_if #(.XLEN(64)) bus ();
  e_stage #(.XLEN(64), .RNONE(4'hF)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Drive one instruction into E, all stats AOK, then settle.
  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] va, input logic [63:0] vb,
                       input logic [63:0] vc, input logic [3:0] dste,
                       input logic [3:0] dstm);
    @(negedge clk);
    bus.E_icode = icode; bus.E_ifun = ifun; bus.E_valA = va; bus.E_valB = vb;
    bus.E_valC = vc; bus.E_dstE = dste; bus.E_dstM = dstm;
    bus.E_stat = 4'h1; bus.m_stat = 4'h1; bus.W_stat = 4'h1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    tick();
    rst = 1'b0;
    n_checks++; if (bus.cc !== 3'b100) begin $display("FAIL reset_cc got %b exp %b", bus.cc, 3'b100); n_fail++; end
    drive(4'h7, 4'h3, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
    n_checks++; if (bus.e_Cnd !== 1'b1) begin $display("FAIL reset_je got %b exp 1", bus.e_Cnd); n_fail++; end
    n_checks++; if (bus.e_valE !== 64'h0) begin $display("FAIL jxx_valE got %h exp 0", bus.e_valE); n_fail++; end
    drive(4'h7, 4'h7, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
    n_checks++; if (bus.e_Cnd !== 1'b0) begin $display("FAIL cond7 got %b exp 0", bus.e_Cnd); n_fail++; end
  endtask

  task automatic test_sub_zero();
    drive(4'h6, 4'h1, 64'h1, 64'h1, 64'h0, 4'h3, 4'hF);
    n_checks++; if (bus.e_valE !== 64'h0) begin $display("FAIL sub_valE got %h exp 0", bus.e_valE); n_fail++; end
    tick();
    n_checks++; if (bus.cc !== 3'b100) begin $display("FAIL sub_cc got %b exp 100", bus.cc); n_fail++; end
    drive(4'h7, 4'h4, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    n_checks++; if (bus.e_Cnd !== 1'b0) begin $display("FAIL jne_after_zero got %b exp 0", bus.e_Cnd); n_fail++; end
  endtask

  task automatic test_add_ovf();
    drive(4'h6, 4'h0, MAXP, MAXP, 64'h0, 4'h3, 4'hF);
    n_checks++; if (bus.e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin $display("FAIL add_valE got %h exp fffffffffffffffe", bus.e_valE); n_fail++; end
    tick();
    n_checks++; if (bus.cc !== 3'b011) begin $display("FAIL add_cc got %b exp 011", bus.cc); n_fail++; end
    drive(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    n_checks++; if (bus.e_Cnd !== 1'b0) begin $display("FAIL jl_ovf got %b exp 0", bus.e_Cnd); n_fail++; end
    drive(4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    n_checks++; if (bus.e_Cnd !== 1'b0) begin $display("FAIL jle_ovf got %b exp 0", bus.e_Cnd); n_fail++; end
    drive(4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    n_checks++; if (bus.e_Cnd !== 1'b1) begin $display("FAIL jge_ovf got %b exp 1", bus.e_Cnd); n_fail++; end
    drive(4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    n_checks++; if (bus.e_Cnd !== 1'b1) begin $display("FAIL jg_ovf got %b exp 1", bus.e_Cnd); n_fail++; end
  endtask

  // cc is 011 on entry: an OPQ must see the old flags, not its own.
  task automatic test_cnd_timing();
    drive(4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 4'h3, 4'hF);
    n_checks++; if (bus.e_Cnd !== 1'b0) begin $display("FAIL own_flags_hidden got %b exp 0", bus.e_Cnd); n_fail++; end
    tick();
    drive(4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    n_checks++; if (bus.e_Cnd !== 1'b1) begin $display("FAIL next_sees_flags got %b exp 1", bus.e_Cnd); n_fail++; end
  endtask

  task automatic test_cmov();
    drive(4'h6, 4'h1, 64'h1, MINN, 64'h0, 4'h3, 4'hF);
    n_checks++; if (bus.e_valE !== MAXP) begin $display("FAIL sub_ovf_valE got %h exp %h", bus.e_valE, MAXP); n_fail++; end
    tick();
    n_checks++; if (bus.cc !== 3'b001) begin $display("FAIL sub_ovf_cc got %b exp 001", bus.cc); n_fail++; end
    drive(4'h2, 4'h3, 64'hABCD, 64'h9999, 64'h0, 4'h2, 4'hF);
    n_checks++; if (bus.e_dstE !== 4'hF) begin $display("FAIL cmove_squash got %h exp f", bus.e_dstE); n_fail++; end
    n_checks++; if (bus.e_valE !== 64'hABCD) begin $display("FAIL cmov_valE got %h exp abcd", bus.e_valE); n_fail++; end
    drive(4'h2, 4'h2, 64'hABCD, 64'h9999, 64'h0, 4'h2, 4'hF);
    n_checks++; if (bus.e_dstE !== 4'h2) begin $display("FAIL cmovl_taken got %h exp 2", bus.e_dstE); n_fail++; end
    drive(4'h6, 4'h3, 64'h55, 64'h55, 64'h0, 4'h3, 4'hF);
    tick();
    drive(4'h2, 4'h3, 64'hABCD, 64'h0, 64'h0, 4'h2, 4'hF);
    n_checks++; if (bus.e_dstE !== 4'h2) begin $display("FAIL cmove_taken got %h exp 2", bus.e_dstE); n_fail++; end
    drive(4'h2, 4'h9, 64'h1, 64'h0, 64'h0, 4'h5, 4'hF);
    n_checks++; if (bus.e_dstE !== 4'hF) begin $display("FAIL cmov_badcond got %h exp f", bus.e_dstE); n_fail++; end
  endtask

  // cc is 100 on entry; none of these instructions may change it.
  task automatic test_stack_mem();
    drive(4'hA, 4'h0, 64'h7, 64'h100, 64'h0, 4'h4, 4'hF);
    n_checks++; if (bus.e_valE !== 64'hF8) begin $display("FAIL push_valE got %h exp f8", bus.e_valE); n_fail++; end
    tick();
    n_checks++; if (bus.cc !== 3'b100) begin $display("FAIL push_cc got %b exp 100", bus.cc); n_fail++; end
    drive(4'hB, 4'h0, 64'h7, 64'h100, 64'h0, 4'h4, 4'h3);
    n_checks++; if (bus.e_valE !== 64'h108) begin $display("FAIL pop_valE got %h exp 108", bus.e_valE); n_fail++; end
    tick();
    n_checks++; if (bus.cc !== 3'b100) begin $display("FAIL pop_cc got %b exp 100", bus.cc); n_fail++; end
    drive(4'h8, 4'h0, 64'h0, 64'h200, 64'h0, 4'h4, 4'hF);
    n_checks++; if (bus.e_valE !== 64'h1F8) begin $display("FAIL call_valE got %h exp 1f8", bus.e_valE); n_fail++; end
    drive(4'h9, 4'h0, 64'h0, 64'h200, 64'h0, 4'h4, 4'hF);
    n_checks++; if (bus.e_valE !== 64'h208) begin $display("FAIL ret_valE got %h exp 208", bus.e_valE); n_fail++; end
    drive(4'h5, 4'h0, 64'h0, 64'h1000, 64'h10, 4'hF, 4'h6);
    n_checks++; if (bus.e_valE !== 64'h1010) begin $display("FAIL mrmov_valE got %h exp 1010", bus.e_valE); n_fail++; end
    drive(4'h3, 4'h0, 64'h5, 64'h1000, 64'h1234, 4'h6, 4'hF);
    n_checks++; if (bus.e_valE !== 64'h1234) begin $display("FAIL irmov_valE got %h exp 1234", bus.e_valE); n_fail++; end
    drive(4'h0, 4'h0, 64'h5, 64'h6, 64'h7, 4'hF, 4'hF);
    n_checks++; if (bus.e_valE !== 64'h0) begin $display("FAIL halt_valE got %h exp 0", bus.e_valE); n_fail++; end
  endtask

  task automatic test_logic();
    drive(4'h6, 4'h2, 64'hFF00, 64'h0F0F, 64'h0, 4'h3, 4'hF);
    n_checks++; if (bus.e_valE !== 64'h0F00) begin $display("FAIL and_valE got %h exp f00", bus.e_valE); n_fail++; end
    tick();
    n_checks++; if (bus.cc !== 3'b000) begin $display("FAIL and_cc got %b exp 000", bus.cc); n_fail++; end
    drive(4'h6, 4'h3, 64'hF0F0, 64'hFFFF, 64'h0, 4'h3, 4'hF);
    n_checks++; if (bus.e_valE !== 64'h0F0F) begin $display("FAIL xor_valE got %h exp f0f", bus.e_valE); n_fail++; end
    drive(4'h6, 4'h8, 64'h3, 64'h4, 64'h0, 4'h3, 4'hF);
    bus.E_stat = 4'h4; #1;
    n_checks++; if (bus.e_valE !== 64'h0) begin $display("FAIL opq_badfun got %h exp 0", bus.e_valE); n_fail++; end
    tick();
    n_checks++; if (bus.cc !== 3'b000) begin $display("FAIL ins_no_cc got %b exp 000", bus.cc); n_fail++; end
  endtask

  task automatic test_passthrough();
    drive(4'h5, 4'hC, 64'hDEAD_BEEF_0000_1111, 64'h0, 64'h8, 4'h1, 4'h7);
    bus.E_stat = 4'h3; #1;
    n_checks++; if (bus.e_valA !== 64'hDEAD_BEEF_0000_1111) begin $display("FAIL pass_valA got %h", bus.e_valA); n_fail++; end
    n_checks++; if ({bus.e_icode, bus.e_ifun, bus.e_stat, bus.e_dstE, bus.e_dstM} !== 20'h5C317)
      begin $display("FAIL pass_fields got %h exp 5c317", {bus.e_icode, bus.e_ifun, bus.e_stat, bus.e_dstE, bus.e_dstM}); n_fail++; end
  endtask

  task automatic test_exc_suppress();
    drive(4'h6, 4'h0, MAXP, MAXP, 64'h0, 4'h3, 4'hF);
    tick();
    drive(4'h6, 4'h3, 64'hF0, 64'hF0, 64'h0, 4'h3, 4'hF);
    bus.m_stat = 4'h3; tick();
    n_checks++; if (bus.cc !== 3'b011) begin $display("FAIL m_adr_hold got %b exp 011", bus.cc); n_fail++; end
    bus.m_stat = 4'h2; tick();
    n_checks++; if (bus.cc !== 3'b011) begin $display("FAIL m_hlt_hold got %b exp 011", bus.cc); n_fail++; end
    bus.m_stat = 4'h1; bus.W_stat = 4'h4; tick();
    n_checks++; if (bus.cc !== 3'b011) begin $display("FAIL w_ins_hold got %b exp 011", bus.cc); n_fail++; end
    bus.W_stat = 4'h1; bus.E_stat = 4'h2; tick();
    n_checks++; if (bus.cc !== 3'b011) begin $display("FAIL e_hlt_hold got %b exp 011", bus.cc); n_fail++; end
    drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    tick();
    n_checks++; if (bus.cc !== 3'b011) begin $display("FAIL nop_hold got %b exp 011", bus.cc); n_fail++; end
    drive(4'h6, 4'h3, 64'hF0, 64'hF0, 64'h0, 4'h3, 4'hF);
    tick();
    n_checks++; if (bus.cc !== 3'b100) begin $display("FAIL xor_set got %b exp 100", bus.cc); n_fail++; end
  endtask

  task automatic test_reset_priority();
    drive(4'h6, 4'h0, MAXP, MAXP, 64'h0, 4'h3, 4'hF);
    tick();
    n_checks++; if (bus.cc !== 3'b011) begin $display("FAIL pre_rst_cc got %b exp 011", bus.cc); n_fail++; end
    drive(4'h6, 4'h1, 64'h1, MINN, 64'h0, 4'h3, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.cc !== 3'b100) begin $display("FAIL rst_over_opq got %b exp 100", bus.cc); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_sub_zero();
    test_add_ovf();
    test_cnd_timing();
    test_cmov();
    test_stack_mem();
    test_logic();
    test_passthrough();
    test_exc_suppress();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
